// File: rtl/raster_iter_pkg.sv
// Shared types and helpers for the raster sample iterators.
// Holds the datapath sizes, the iterator state encoding and the subsample step function.
package raster_iter_pkg;
    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int LANES  = 4;

    typedef enum logic [0:0] {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    // One-hot MSAA width to fixed-point step between adjacent subsamples.
    function automatic logic [SIGFIG-1:0] delta(input logic [3:0] sub_sample);
        logic [SIGFIG-1:0] d;
        d = {{(SIGFIG-4){1'b0}}, sub_sample};
        return d << (RADIX - 3);
    endfunction
endpackage

// File: rtl/sample_lane_gen.sv
// Combinational lane expander: the group base (bx, by) becomes LANES samples,
// a per-lane inside-row mask and the end-of-row flag.
module sample_lane_gen
    import raster_iter_pkg::*;
(
    input  logic signed [SIGFIG-1:0] bx,
    input  logic signed [SIGFIG-1:0] by,
    input  logic        [SIGFIG-1:0] step,
    input  logic signed [SIGFIG-1:0] ur_x,
    output logic signed [SIGFIG-1:0] lane_s [LANES][2],
    output logic        [LANES-1:0]  lane_mask,
    output logic                     row_end
);
    localparam int W = SIGFIG + 1;

    logic signed [W-1:0] bx_w;
    logic signed [W-1:0] step_w;
    logic signed [W-1:0] urx_w;
    logic signed [W-1:0] last_x_w;
    logic signed [W-1:0] lane_x_w [LANES];

    // One extra bit keeps the far lanes from wrapping past the top of the range.
    always_comb begin
        bx_w     = {bx[SIGFIG-1], bx};
        step_w   = {1'b0, step};
        urx_w    = {ur_x[SIGFIG-1], ur_x};
        for (int i = 0; i < LANES; i++) begin
            lane_x_w[i]  = bx_w + W'(i) * step_w;
            lane_mask[i] = (lane_x_w[i] <= urx_w);
            lane_s[i][0] = lane_x_w[i][SIGFIG-1:0];
            lane_s[i][1] = by;
        end
        last_x_w = bx_w + W'(LANES - 1) * step_w;
        row_end  = (last_x_w >= urx_w);
    end
endmodule

// File: rtl/test_iterator_lanes_chk.sv
// Runtime checks for the lane iterator: lanes stay in the box, the base makes
// progress on every handshake, a stall holds state, subsample is steady in TEST.
module test_iterator_lanes_chk
    import raster_iter_pkg::*;
(
    input logic                     clk,
    input logic                     rst,
    input logic                     test_s,
    input logic                     stall_s,
    input logic                     adv_s,
    input logic                     can_accept_s,
    input logic signed [SIGFIG-1:0] bx_q,
    input logic signed [SIGFIG-1:0] by_q,
    input logic signed [SIGFIG-1:0] bx_d,
    input logic signed [SIGFIG-1:0] by_d,
    input logic signed [SIGFIG-1:0] ll_x,
    input logic signed [SIGFIG-1:0] ll_y,
    input logic signed [SIGFIG-1:0] ur_x,
    input logic signed [SIGFIG-1:0] ur_y,
    input logic        [3:0]        sub_sample,
    input logic        [LANES-1:0]  lane_mask,
    input logic signed [SIGFIG-1:0] sample [LANES][2]
);
    logic        [3:0]        sub_prev_q;
    logic                     test_prev_q;
    logic                     stall_prev_q;
    logic signed [SIGFIG-1:0] bx_prev_q;
    logic signed [SIGFIG-1:0] by_prev_q;

    // Previous-cycle snapshot used by the hold and steadiness checks.
    always_ff @(posedge clk) begin
        sub_prev_q   <= sub_sample;
        test_prev_q  <= test_s && !rst;
        stall_prev_q <= stall_s && !rst;
        bx_prev_q    <= bx_q;
        by_prev_q    <= by_q;
    end

    // Property checks, skipped while reset is applied.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_mask[i]) begin
                    assert (sample[i][0] >= ll_x && sample[i][0] <= ur_x &&
                            sample[i][1] >= ll_y && sample[i][1] <= ur_y);
                end
            end
            if (adv_s) begin
                assert (can_accept_s || bx_d != bx_q || by_d != by_q);
            end
            if (stall_prev_q) begin
                assert (test_s && bx_q == bx_prev_q && by_q == by_prev_q);
            end
            if (test_prev_q && test_s) begin
                assert (sub_sample == sub_prev_q);
            end
        end
    end
endmodule

// File: rtl/test_iterator_lanes.sv
// Multi-lane bounding-box iterator: walks the box bottom-up, left to right,
// emitting LANES adjacent subsamples per cycle with downstream backpressure.
module test_iterator_lanes
    import raster_iter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    input  logic                     ready_R14H,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [LANES][2],
    output logic        [LANES-1:0]  laneMask_R14H,
    output logic                     validSamp_R14H
);
    localparam int LANE_SHIFT = $clog2(LANES);

    state_t                   state_q, state_d;
    logic signed [SIGFIG-1:0] bx_q, bx_d;
    logic signed [SIGFIG-1:0] by_q, by_d;
    logic signed [SIGFIG-1:0] box_q [2][2];
    logic signed [SIGFIG-1:0] box_d [2][2];
    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];

    logic        [SIGFIG-1:0] delta_s;
    logic        [SIGFIG-1:0] step_s;
    logic signed [SIGFIG-1:0] lane_s [LANES][2];
    logic        [LANES-1:0]  lane_mask_s;
    logic                     row_end_s;
    logic                     test_s, top_s, box_end_s, adv_s, can_accept_s, stall_s;

    assign delta_s = delta(subSample_RnnnnU);
    assign step_s  = delta_s << LANE_SHIFT;

    sample_lane_gen u_lane_gen (
        .bx        (bx_q),
        .by        (by_q),
        .step      (delta_s),
        .ur_x      (box_q[1][0]),
        .lane_s    (lane_s),
        .lane_mask (lane_mask_s),
        .row_end   (row_end_s)
    );

    // Handshake and walk control flags.
    always_comb begin
        test_s       = (state_q == TEST_STATE);
        top_s        = (by_q == box_q[1][1]);
        box_end_s    = row_end_s && top_s;
        adv_s        = test_s && ready_R14H;
        can_accept_s = !test_s || (adv_s && box_end_s);
        stall_s      = test_s && !ready_R14H;
        halt_RnnnnL  = rst || !validTri_R13H || can_accept_s;
    end

    // Next-state: accept a new triangle, retire to WAIT, or step the group base.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        box_d   = box_q;
        tri_d   = tri_q;
        color_d = color_q;
        if (can_accept_s && validTri_R13H) begin
            state_d = TEST_STATE;
            box_d   = box_R13S;
            tri_d   = tri_R13S;
            color_d = color_R13U;
            bx_d    = box_R13S[0][0];
            by_d    = box_R13S[0][1];
        end else if (can_accept_s) begin
            state_d = WAIT_STATE;
        end else if (adv_s && row_end_s) begin
            bx_d = box_q[0][0];
            by_d = by_q + delta_s;
        end else if (adv_s) begin
            bx_d = bx_q + step_s;
        end else begin
            state_d = state_q;
        end
    end

    // State and data registers; everything freezes while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_STATE;
            bx_q    <= '0;
            by_q    <= '0;
            box_q   <= '{default: '0};
            tri_q   <= '{default: '0};
            color_q <= '{default: '0};
        end else if (!stall_s) begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            box_q   <= box_d;
            tri_q   <= tri_d;
            color_q <= color_d;
        end
    end

    // Samples are zeroed outside TEST so an idle iterator shows all-zero outputs.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sample_R14S[i][0] = test_s ? lane_s[i][0] : '0;
            sample_R14S[i][1] = test_s ? lane_s[i][1] : '0;
        end
        laneMask_R14H  = test_s ? lane_mask_s : '0;
        validSamp_R14H = test_s;
        tri_R14S       = tri_q;
        color_R14U     = color_q;
    end

    test_iterator_lanes_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .test_s       (test_s),
        .stall_s      (stall_s),
        .adv_s        (adv_s),
        .can_accept_s (can_accept_s),
        .bx_q         (bx_q),
        .by_q         (by_q),
        .bx_d         (bx_d),
        .by_d         (by_d),
        .ll_x         (box_q[0][0]),
        .ll_y         (box_q[0][1]),
        .ur_x         (box_q[1][0]),
        .ur_y         (box_q[1][1]),
        .sub_sample   (subSample_RnnnnU),
        .lane_mask    (laneMask_R14H),
        .sample       (sample_R14S)
    );
endmodule
